// File: rtl/hdr_exposure_pair_aligner.sv
// rtl/hdr_exposure_pair_aligner.sv - frame-aligns long/short exposure pixel streams into pairs for HDR merge
module hdr_exposure_pair_aligner #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s0_data,
    input  logic                  s0_sof,
    input  logic                  s0_valid,
    output logic                  s0_ready,
    input  logic [DATA_WIDTH-1:0] s1_data,
    input  logic                  s1_sof,
    input  logic                  s1_valid,
    output logic                  s1_ready,
    output logic [DATA_WIDTH-1:0] m_data0,
    output logic [DATA_WIDTH-1:0] m_data1,
    output logic                  m_sof,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  resync_pulse,
    output logic [15:0]           resync_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic {SYNC_WAIT, STREAM} state_t;

    state_t state;

    logic [DATA_WIDTH:0]   mem [2][FIFO_DEPTH];
    logic [DATA_WIDTH:0]   in_word [2];
    logic [DATA_WIDTH-1:0] h_data [2];
    logic [PW-1:0]         wp [2];
    logic [PW-1:0]         wp_vis [2];
    logic [PW-1:0]         rp [2];
    logic [PW-1:0]         wp_nx [2];
    logic [PW-1:0]         rp_nx [2];
    logic [1:0]            rdy;
    logic [1:0]            push;
    logic [1:0]            pop;
    logic [1:0]            h_vld;
    logic [1:0]            h_sof;
    logic                  out_free;
    logic                  load;
    logic                  mismatch;

    assign in_word[0] = {s0_sof, s0_data};
    assign in_word[1] = {s1_sof, s1_data};
    assign push       = {s1_valid & rdy[1], s0_valid & rdy[0]};
    assign s0_ready   = rdy[0];
    assign s1_ready   = rdy[1];
    assign out_free   = !m_valid || m_ready;

    // Heads are judged against a one-cycle-delayed write pointer, so a fresh write never falls through.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            h_vld[i]  = (wp_vis[i] != rp[i]);
            h_sof[i]  = mem[i][rp[i][AW-1:0]][DATA_WIDTH];
            h_data[i] = mem[i][rp[i][AW-1:0]][DATA_WIDTH-1:0];
            wp_nx[i]  = wp[i] + {{AW{1'b0}}, push[i]};
            rp_nx[i]  = rp[i] + {{AW{1'b0}}, pop[i]};
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
                mem[i][wp[i][AW-1:0]] <= in_word[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                wp[i]     <= '0;
                wp_vis[i] <= '0;
                rp[i]     <= '0;
            end
            rdy <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                wp[i]     <= wp_nx[i];
                wp_vis[i] <= wp[i];
                rp[i]     <= rp_nx[i];
                // Full when the pointers differ only in the wrap bit.
                rdy[i]    <= !((wp_nx[i][AW] != rp_nx[i][AW]) &&
                               (wp_nx[i][AW-1:0] == rp_nx[i][AW-1:0]));
            end
        end
    end

    always_comb begin
        pop      = 2'b00;
        load     = 1'b0;
        mismatch = 1'b0;
        case (state)
            SYNC_WAIT: begin
                if (h_vld[0] && !h_sof[0]) pop[0] = 1'b1;
                if (h_vld[1] && !h_sof[1]) pop[1] = 1'b1;
                if ((&h_vld) && (&h_sof) && out_free) begin
                    pop  = 2'b11;
                    load = 1'b1;
                end
            end
            STREAM: begin
                if ((&h_vld) && out_free) begin
                    if (h_sof[0] == h_sof[1]) begin
                        pop  = 2'b11;
                        load = 1'b1;
                    end else begin
                        mismatch = 1'b1;
                    end
                end
            end
            default: begin
                pop = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= SYNC_WAIT;
            m_data0      <= '0;
            m_data1      <= '0;
            m_sof        <= 1'b0;
            m_valid      <= 1'b0;
            resync_pulse <= 1'b0;
            resync_cnt   <= '0;
        end else begin
            resync_pulse <= mismatch;
            if (mismatch) begin
                state <= SYNC_WAIT;
                if (resync_cnt != 16'hFFFF) begin
                    resync_cnt <= resync_cnt + 16'd1;
                end
            end else if (load) begin
                state <= STREAM;
            end
            if (load) begin
                m_data0 <= h_data[0];
                m_data1 <= h_data[1];
                m_sof   <= h_sof[0];
                m_valid <= 1'b1;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hdr_exposure_pair_aligner.sv
// tb/tb_hdr_exposure_pair_aligner.sv - scoreboard bench for hdr_exposure_pair_aligner
module tb_hdr_exposure_pair_aligner;

    logic        clk;
    logic        rst_n;
    logic [31:0] s0_data, s1_data;
    logic        s0_sof, s0_valid, s0_ready;
    logic        s1_sof, s1_valid, s1_ready;
    logic [31:0] m_data0, m_data1;
    logic        m_sof, m_valid, m_ready;
    logic        resync_pulse;
    logic [15:0] resync_cnt;

    hdr_exposure_pair_aligner #(.DATA_WIDTH(32), .FIFO_DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .s0_data(s0_data), .s0_sof(s0_sof), .s0_valid(s0_valid), .s0_ready(s0_ready),
        .s1_data(s1_data), .s1_sof(s1_sof), .s1_valid(s1_valid), .s1_ready(s1_ready),
        .m_data0(m_data0), .m_data1(m_data1), .m_sof(m_sof), .m_valid(m_valid),
        .m_ready(m_ready), .resync_pulse(resync_pulse), .resync_cnt(resync_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [64:0] exp_q [$];
    logic [32:0] q0 [$];
    logic [32:0] q1 [$];

    int          acc0, pulses, first_acc0, first_acc1, first_mv;
    int          pair_n, pair_first, pair_last;
    logic        prev_hold;
    logic [64:0] prev_word;
    logic        d0, d1;

    task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor samples two time units before each rising edge.
    always @(negedge clk) begin
        #3;
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold)
                check_eq("hold_stable", 72'({m_valid, m_sof, m_data0, m_data1}), 72'({1'b1, prev_word}));
            if (s0_valid && s0_ready) begin
                acc0++;
                if (first_acc0 < 0) first_acc0 = cyc;
            end
            if (s1_valid && s1_ready && first_acc1 < 0) first_acc1 = cyc;
            if (m_valid && first_mv < 0) first_mv = cyc;
            if (resync_pulse) pulses++;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_pair", 72'({m_sof, m_data0, m_data1}), 72'(0));
                end else begin
                    check_eq("pair", 72'({m_sof, m_data0, m_data1}), 72'(exp_q.pop_front()));
                end
                if (pair_n == 0) pair_first = cyc;
                pair_last = cyc;
                pair_n++;
            end
            prev_hold = m_valid && !m_ready;
            prev_word = {m_sof, m_data0, m_data1};
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear_stats();
        acc0 = 0; pulses = 0; first_acc0 = -1; first_acc1 = -1; first_mv = -1;
        pair_n = 0; pair_first = 0; pair_last = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        exp_q.delete();
        q0.delete();
        q1.delete();
        step(2);
        rst_n = 1'b1;
        clear_stats();
    endtask

    task automatic drive0();
        int wt;
        while (q0.size() > 0) begin
            logic [32:0] b;
            b = q0.pop_front();
            s0_valid = 1'b1; s0_sof = b[32]; s0_data = b[31:0];
            wt = 0;
            while (!s0_ready && wt < 500) begin
                step(1);
                wt++;
            end
            if (!s0_ready) begin
                check_eq("s0_ready_timeout", 72'(0), 72'(1));
                q0.delete();
            end
            step(1);
        end
        s0_valid = 1'b0;
    endtask

    task automatic drive1();
        int wt;
        while (q1.size() > 0) begin
            logic [32:0] b;
            b = q1.pop_front();
            s1_valid = 1'b1; s1_sof = b[32]; s1_data = b[31:0];
            wt = 0;
            while (!s1_ready && wt < 500) begin
                step(1);
                wt++;
            end
            if (!s1_ready) begin
                check_eq("s1_ready_timeout", 72'(0), 72'(1));
                q1.delete();
            end
            step(1);
        end
        s1_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 300) begin
            step(1);
            w++;
        end
        check_eq({"drain_", tag}, 72'(exp_q.size()), 72'(0));
    endtask

    task automatic exp_pair(input logic sof, input logic [31:0] a, input logic [31:0] b);
        exp_q.push_back({sof, a, b});
    endtask

    initial begin
        int w;
        rst_n = 1'b0; m_ready = 1'b1;
        s0_valid = 1'b0; s0_sof = 1'b0; s0_data = '0;
        s1_valid = 1'b0; s1_sof = 1'b0; s1_data = '0;
        clear_stats();
        step(2);
        check_eq("rst_m_valid", 72'(m_valid), 72'(0));
        check_eq("rst_m_sof", 72'(m_sof), 72'(0));
        check_eq("rst_m_data", 72'({m_data0, m_data1}), 72'(0));
        check_eq("rst_pulse", 72'(resync_pulse), 72'(0));
        check_eq("rst_cnt", 72'(resync_cnt), 72'(0));
        check_eq("rst_ready", 72'({s0_ready, s1_ready}), 72'(0));

        // 1: aligned frames, latency and back-to-back pairs
        do_reset();
        m_ready = 1'b1;
        q0 = '{{1'b1, 32'h11}, {1'b0, 32'h12}, {1'b0, 32'h13}};
        q1 = '{{1'b1, 32'h21}, {1'b0, 32'h22}, {1'b0, 32'h23}};
        exp_pair(1, 32'h11, 32'h21); exp_pair(0, 32'h12, 32'h22); exp_pair(0, 32'h13, 32'h23);
        fork drive0(); drive1(); join
        wait_drain("t1");
        check_eq("t1_latency", 72'(first_mv - ((first_acc0 > first_acc1) ? first_acc0 : first_acc1)), 72'(3));
        check_eq("t1_pairs", 72'(pair_n), 72'(3));
        check_eq("t1_consecutive", 72'(pair_last - pair_first), 72'(2));
        check_eq("t1_cnt", 72'(resync_cnt), 72'(0));

        // 2: skewed start, leading non-sof beats on s1 discarded
        do_reset();
        q0 = '{{1'b1, 32'h11}, {1'b0, 32'h12}};
        q1 = '{{1'b0, 32'hA1}, {1'b0, 32'hA2}, {1'b0, 32'hA3}, {1'b1, 32'h21}, {1'b0, 32'h22}};
        exp_pair(1, 32'h11, 32'h21); exp_pair(0, 32'h12, 32'h22);
        fork drive0(); drive1(); join
        wait_drain("t2");
        step(3);
        check_eq("t2_pulses", 72'(pulses), 72'(0));
        check_eq("t2_cnt", 72'(resync_cnt), 72'(0));
        check_eq("t2_pairs", 72'(pair_n), 72'(2));

        // 3: mid-frame mismatch and recovery
        do_reset();
        q0 = '{{1'b1, 32'h11}, {1'b0, 32'h12}, {1'b1, 32'h51}, {1'b0, 32'h52}};
        q1 = '{{1'b1, 32'h21}, {1'b0, 32'h22}, {1'b0, 32'hB1}, {1'b0, 32'hB2},
               {1'b1, 32'h61}, {1'b0, 32'h62}};
        exp_pair(1, 32'h11, 32'h21); exp_pair(0, 32'h12, 32'h22);
        exp_pair(1, 32'h51, 32'h61); exp_pair(0, 32'h52, 32'h62);
        fork drive0(); drive1(); join
        wait_drain("t3");
        step(3);
        check_eq("t3_pulses", 72'(pulses), 72'(1));
        check_eq("t3_cnt", 72'(resync_cnt), 72'(1));

        // 4: backpressure with s0 streaming
        do_reset();
        m_ready = 1'b0;
        d0 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            q0.push_back({(k == 0), 32'h300 + 32'(k)});
            exp_pair((k == 0), 32'h300 + 32'(k), (k == 0) ? 32'h21 : 32'h400 + 32'(k));
        end
        q1.push_back({1'b1, 32'h21});
        fork
            begin drive0(); d0 = 1'b1; end
            drive1();
        join_none
        step(22);
        check_eq("t4_accepted", 72'(acc0), 72'(17));
        check_eq("t4_ready_low", 72'(s0_ready), 72'(0));
        check_eq("t4_held", 72'({m_valid, m_sof, m_data0, m_data1}), 72'({1'b1, 1'b1, 32'h300, 32'h21}));
        for (int k = 1; k < 20; k++) q1.push_back({1'b0, 32'h400 + 32'(k)});
        d1 = 1'b0;
        fork begin drive1(); d1 = 1'b1; end join_none
        m_ready = 1'b1;
        wait_drain("t4");
        w = 0;
        while (!(d0 && d1) && w < 200) begin step(1); w++; end
        check_eq("t4_drivers_done", 72'({d0, d1}), 72'(2'b11));
        check_eq("t4_pairs", 72'(pair_n), 72'(20));

        // 5: fill/drain FIFO0 three times across the pointer wrap
        do_reset();
        m_ready = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 16; k++)
                q0.push_back({(r == 0 && k == 0), 32'h1000 + 32'(r * 16 + k)});
            drive0();
            step(3);
            check_eq("t5_full_ready", 72'(s0_ready), 72'(0));
            for (int k = 0; k < 16; k++) begin
                q1.push_back({(r == 0 && k == 0), 32'h2000 + 32'(r * 16 + k)});
                exp_pair((r == 0 && k == 0), 32'h1000 + 32'(r * 16 + k), 32'h2000 + 32'(r * 16 + k));
            end
            drive1();
            wait_drain("t5");
            step(2);
            check_eq("t5_drained_ready", 72'(s0_ready), 72'(1));
        end
        check_eq("t5_pairs", 72'(pair_n), 72'(48));

        // 6: asynchronous reset while a pair is held
        do_reset();
        m_ready = 1'b0;
        q0 = '{{1'b1, 32'h11}, {1'b0, 32'h12}};
        q1 = '{{1'b1, 32'h21}, {1'b0, 32'h22}};
        fork drive0(); drive1(); join
        w = 0;
        while (!m_valid && w < 50) begin step(1); w++; end
        check_eq("t6_valid_before", 72'(m_valid), 72'(1));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_async_valid", 72'(m_valid), 72'(0));
        check_eq("t6_async_sof", 72'(m_sof), 72'(0));
        check_eq("t6_async_pulse", 72'(resync_pulse), 72'(0));
        exp_q.delete();
        step(2);
        rst_n = 1'b1;
        clear_stats();
        m_ready = 1'b1;
        q0 = '{{1'b0, 32'h71}, {1'b0, 32'h72}, {1'b1, 32'h81}, {1'b0, 32'h82}};
        q1 = '{{1'b0, 32'h91}, {1'b1, 32'hA1}, {1'b0, 32'hA2}};
        exp_pair(1, 32'h81, 32'hA1); exp_pair(0, 32'h82, 32'hA2);
        fork drive0(); drive1(); join
        wait_drain("t6");
        step(3);
        check_eq("t6_pairs", 72'(pair_n), 72'(2));
        check_eq("t6_cnt", 72'(resync_cnt), 72'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
